pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL provide parameter PC_W, default 32, PC register and address width (16..32).
REQ-002 SHALL provide parameter RESET_VECTOR, default 32'h0000_3000, PC value loaded on reset (truncated to PC_W).
REQ-003 SHALL provide port clk  input  1  rising-edge clock.
REQ-004 SHALL provide port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL provide port stall  input  1  hold PC and all state this cycle.
REQ-006 SHALL provide port op  input  6  opcode of the instruction at pc.
REQ-007 SHALL provide port funct  input  6  function field, used only when op==6'b000000.
REQ-008 SHALL provide port rs_val  input  32  register rs value (compare operand, JR/JALR target).
REQ-009 SHALL provide port rt_val  input  32  register rt value (compare operand).
REQ-010 SHALL provide port imm16  input  16  branch offset in words.
REQ-011 SHALL provide port target26  input  26  jump index.
REQ-012 SHALL provide port pc  output  PC_W  current fetch address (registered).
REQ-013 SHALL provide port pc_plus4  output  PC_W  pc+4, combinational.
REQ-014 SHALL provide port link_addr  output  PC_W  return address for JAL/JALR.
REQ-015 SHALL provide port link_we  output  1  high when instruction at pc is JAL or JALR.
REQ-016 SHALL provide port taken  output  1  high when instruction at pc redirects control flow.

Function
REQ-017 Decode: BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111, J 000010, JAL 000011, JR op 000000/funct 001000, JALR op 000000/funct 001001; all else sequential.
REQ-018 Conditions: BEQ rs==rt; BNE rs!=rt; BLEZ signed rs<=0; BGTZ signed rs>0; J/JAL/JR/JALR always taken.
REQ-019 Branch target = pc+4 + (sign-extended imm16 << 2), modulo 2^PC_W.
REQ-020 J/JAL target = {pc_plus4[PC_W-1:28], target26, 2'b00}; for PC_W<=28 the low PC_W bits of {target26,2'b00}.
REQ-021 JR/JALR target = rs_val[PC_W-1:0] with bits [1:0] forced to 0.
REQ-022 All address arithmetic wraps silently at PC_W bits; pc_plus4 of all-ones-minus-3 is 0.
REQ-023 pc SHALL update only on rising clk when stall==0; stall==1 holds pc and internal state exactly.
REQ-024 taken and link_we are combinational from current inputs and asserted regardless of stall.
REQ-025 Without delay slots: next pc = target when taken, else pc+4; link_addr = pc+8? no: link_addr = pc+4.

Reset
REQ-026 rst SHALL asynchronously force pc=RESET_VECTOR and clear all internal state, including mid-stall or mid-pending.
REQ-027 On the first clock after rst deasserts, fetch proceeds from RESET_VECTOR with no pending redirect.

Configuration
REQ-028 Macro PC_SEQUENCER_DELAY_SLOT_EN SHALL select MIPS branch-delay-slot behaviour; absent, REQ-025 applies.
REQ-029 With macro: two-state FSM NORMAL/PENDING plus PC_W-bit pending_target register.
REQ-030 NORMAL, taken, not stalled: pc<=pc+4, pending_target<=target, state<=PENDING.
REQ-031 PENDING, not stalled: pc<=pending_target, state<=NORMAL; control instruction in delay slot is ignored (taken still reported, no second redirect).
REQ-032 PENDING with stall: hold pc, state and pending_target.
REQ-033 With macro, link_addr = pc+8; without, link_addr = pc+4.

Verification
REQ-034 Reset: assert rst mid-run -> pc==32'h0000_3000 immediately, before next clk edge.
REQ-035 BEQ at pc 0x3000, rs=rt=5, imm16=0xFFFF, no macro -> next pc 0x3000, taken=1.
REQ-036 BGTZ rs=0x8000_0000 -> taken=0, next pc 0x3004; BLEZ same rs -> taken=1.
REQ-037 JAL at 0x3010, target26=0x0000100 -> next pc 0x0000_0400, link_we=1, link_addr 0x3014 (0x3018 with macro).
REQ-038 Macro defined: J at 0x3000 then BEQ-taken in slot with stall one cycle -> pc sequence 0x3000,0x3004,0x3004,target of J.
REQ-039 JR rs_val=0x0000_3007, stall=1 for 3 cycles -> pc held, then 0x3004 after stall release.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: decodes branches and jumps at pc and produces the next fetch address.
// Define PC_SEQUENCER_DELAY_SLOT_EN to get MIPS branch-delay-slot sequencing (redirect after one slot).
module pc_sequencer #(
  parameter int          PC_W         = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_3000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [5:0]      op,
  input  logic [5:0]      funct,
  input  logic [31:0]     rs_val,
  input  logic [31:0]     rt_val,
  input  logic [15:0]     imm16,
  input  logic [25:0]     target26,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic [PC_W-1:0] link_addr,
  output logic            link_we,
  output logic            taken
);

  localparam logic [PC_W-1:0] RST_PC = RESET_VECTOR[PC_W-1:0];

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] tgt;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] j_tgt;
  logic [PC_W-1:0] jr_tgt;
  logic [31:0]     br_off;
  logic [31:0]     p4_ext;
  logic [31:0]     j32;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + PC_W'(4);

  // All targets are built at 32 bits and truncated, so every PC_W wraps the same way.
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};
  assign br_tgt = pc_plus4 + br_off[PC_W-1:0];
  assign p4_ext = 32'(pc_plus4);
  assign j32    = (p4_ext & 32'hF000_0000) | {4'b0000, target26, 2'b00};
  assign j_tgt  = j32[PC_W-1:0];
  assign jr_tgt = rs_val[PC_W-1:0] & ~PC_W'(3);

  always_comb begin
    taken   = 1'b0;
    link_we = 1'b0;
    tgt     = pc_plus4;
    case (op)
      OP_BEQ:  begin taken = (rs_val == rt_val);          tgt = br_tgt; end
      OP_BNE:  begin taken = (rs_val != rt_val);          tgt = br_tgt; end
      OP_BLEZ: begin taken = ($signed(rs_val) <= 32'sd0); tgt = br_tgt; end
      OP_BGTZ: begin taken = ($signed(rs_val) >  32'sd0); tgt = br_tgt; end
      OP_J:    begin taken = 1'b1;                        tgt = j_tgt;  end
      OP_JAL:  begin taken = 1'b1; link_we = 1'b1;        tgt = j_tgt;  end
      OP_SPECIAL: begin
        if (funct == FN_JR) begin
          taken = 1'b1;
          tgt   = jr_tgt;
        end else if (funct == FN_JALR) begin
          taken   = 1'b1;
          link_we = 1'b1;
          tgt     = jr_tgt;
        end
      end
      default: ;
    endcase
  end

`ifdef PC_SEQUENCER_DELAY_SLOT_EN
  typedef enum logic {NORMAL, PENDING} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pend_q, pend_d, pc_d;

  // Return address skips the delay slot.
  assign link_addr = pc_q + PC_W'(8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= NORMAL;
      pend_q  <= '0;
      pc_q    <= RST_PC;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pc_q    <= pc_d;
    end
  end

  // A control instruction sitting in the delay slot is not allowed to redirect again.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    pc_d    = pc_q;
    if (!stall) begin
      case (state_q)
        NORMAL: begin
          pc_d = pc_plus4;
          if (taken) begin
            pend_d  = tgt;
            state_d = PENDING;
          end
        end
        PENDING: begin
          pc_d    = pend_q;
          state_d = NORMAL;
        end
        default: state_d = NORMAL;
      endcase
    end
  end
`else
  logic [PC_W-1:0] pc_d;

  assign link_addr = pc_plus4;

  always_comb begin
    pc_d = pc_q;
    if (!stall) pc_d = taken ? tgt : pc_plus4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RST_PC;
    else     pc_q <= pc_d;
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: per-cycle comparison against an architectural model plus directed literal checks.
module tb_pc_sequencer;
  localparam int PC_W = 32;

`ifdef PC_SEQUENCER_DELAY_SLOT_EN
  localparam logic [31:0] LINK_OFF = 32'd8;
`else
  localparam logic [31:0] LINK_OFF = 32'd4;
`endif

  localparam logic [5:0] SEQ = 6'b000000, J = 6'b000010, JAL = 6'b000011, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, BLEZ = 6'b000110, BGTZ = 6'b000111, LW = 6'b100011;

  logic clk = 1'b0;
  logic rst, stall, link_we, taken;
  logic [5:0]  op, funct;
  logic [31:0] rs_val, rt_val, pc, pc_plus4, link_addr;
  logic [15:0] imm16;
  logic [25:0] target26;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_W(PC_W), .RESET_VECTOR(32'h0000_3000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .op(op), .funct(funct),
    .rs_val(rs_val), .rt_val(rt_val), .imm16(imm16), .target26(target26),
    .pc(pc), .pc_plus4(pc_plus4), .link_addr(link_addr),
    .link_we(link_we), .taken(taken)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Architectural model
  logic [31:0] m_pc, m_tgt;
  bit          m_pend;

  function automatic bit exp_taken();
    case (op)
      BEQ:  return rs_val == rt_val;
      BNE:  return rs_val != rt_val;
      BLEZ: return int'(rs_val) <= 0;
      BGTZ: return int'(rs_val) > 0;
      J, JAL: return 1'b1;
      SEQ:  return (funct == 6'd8) || (funct == 6'd9);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit exp_link();
    return (op == JAL) || (op == SEQ && funct == 6'd9);
  endfunction

  function automatic logic [31:0] exp_target();
    if (op inside {BEQ, BNE, BLEZ, BGTZ})
      return m_pc + 32'd4 + 32'(4 * int'($signed(imm16)));
    if (op == J || op == JAL)
      return ((m_pc + 32'd4) & 32'hF000_0000) | (32'(target26) * 32'd4);
    return rs_val & 32'hFFFF_FFFC;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 32'h0000_3000; m_pend = 1'b0; m_tgt = '0;
    end else if (!stall) begin
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
      if (m_pend) begin
        m_pc = m_tgt; m_pend = 1'b0;
      end else begin
        if (exp_taken()) begin m_tgt = exp_target(); m_pend = 1'b1; end
        m_pc = m_pc + 32'd4;
      end
`else
      m_pc = exp_taken() ? exp_target() : m_pc + 32'd4;
`endif
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      check("link_addr", link_addr, m_pc + LINK_OFF);
      check("taken", {31'b0, taken}, {31'b0, exp_taken()});
      check("link_we", {31'b0, link_we}, {31'b0, exp_link()});
    end
  end

  task automatic set(input logic [5:0] o, input logic [5:0] f, input logic [31:0] rs,
                     input logic [31:0] rt, input logic [15:0] im, input logic [25:0] tg,
                     input logic st);
    op = o; funct = f; rs_val = rs; rt_val = rt; imm16 = im; target26 = tg; stall = st;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    set(SEQ, 6'd0, 0, 0, 0, 0, 1'b0);
    #2 check("reset_pc", pc, 32'h3000);
    tick(); rst = 1'b0;

`ifndef PC_SEQUENCER_DELAY_SLOT_EN
    set(BEQ, 6'd0, 5, 5, 16'hFFFF, 0, 1'b0);
    #1 check("beq_taken", {31'b0, taken}, 32'd1);
    tick(); check("beq_pc", pc, 32'h3000);
    set(BGTZ, 6'd0, 32'h8000_0000, 0, 16'h0002, 0, 1'b0);
    #1 check("bgtz_neg_taken", {31'b0, taken}, 32'd0);
    tick(); check("bgtz_pc", pc, 32'h3004);
    set(BLEZ, 6'd0, 32'h8000_0000, 0, 16'h0002, 0, 1'b0);
    #1 check("blez_neg_taken", {31'b0, taken}, 32'd1);
    tick(); check("blez_pc", pc, 32'h3010);
    set(JAL, 6'd0, 0, 0, 0, 26'h0000100, 1'b0);
    #1 check("jal_link_we", {31'b0, link_we}, 32'd1);
    check("jal_link_addr", link_addr, 32'h3014);
    tick(); check("jal_pc", pc, 32'h0000_0400);
    set(SEQ, 6'd8, 32'h0000_3007, 0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); check("jr_stall_hold", pc, 32'h0000_0400);
    end
    stall = 1'b0;
    tick(); check("jr_pc", pc, 32'h3004);
`else
    set(J, 6'd0, 0, 0, 0, 26'h0000100, 1'b0);
    tick(); check("ds_slot_pc", pc, 32'h3004);
    set(BEQ, 6'd0, 5, 5, 16'h0010, 0, 1'b1);
    #1 check("ds_slot_taken", {31'b0, taken}, 32'd1);
    tick(); check("ds_stall_pc", pc, 32'h3004);
    stall = 1'b0;
    tick(); check("ds_redirect_pc", pc, 32'h0000_0400);
    set(JAL, 6'd0, 0, 0, 0, 26'h0000100, 1'b0);
    #1 check("jal_link_addr", link_addr, 32'h0408);
    tick(); check("jal_slot_pc", pc, 32'h0404);
    set(SEQ, 6'd0, 0, 0, 0, 0, 1'b0);
    tick(); check("jal_pc", pc, 32'h0400);
`endif

    // Mixed patterns covered by the per-cycle model
    set(BNE,  6'd0,  7, 9, 16'h0004, 0, 1'b0); tick();
    set(BEQ,  6'd0,  7, 9, 16'h0004, 0, 1'b0); tick();
    set(SEQ,  6'h20, 1, 2, 16'h0000, 0, 1'b0); tick();
    set(LW,   6'd8,  1, 2, 16'h0000, 0, 1'b0); tick();
    set(BGTZ, 6'd0,  1, 0, 16'hFFF0, 0, 1'b0); tick();
    set(BLEZ, 6'd0,  1, 0, 16'h0008, 0, 1'b0); tick();
    set(SEQ,  6'd9,  32'h0000_5002, 0, 0, 0, 1'b0); tick();
    set(J,    6'd0,  0, 0, 0, 26'h3FF_FFFF, 1'b0); tick();
    set(SEQ,  6'd0,  0, 0, 0, 0, 1'b0); tick();

    // Address wrap at the top of the space
    set(SEQ, 6'd8, 32'hFFFF_FFFF, 0, 0, 0, 1'b0); tick();
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
    set(SEQ, 6'd0, 0, 0, 0, 0, 1'b0); tick();
`endif
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    set(SEQ, 6'd0, 0, 0, 0, 0, 1'b0); tick();
    check("wrap_seq_pc", pc, 32'h0);
    set(BEQ, 6'd0, 3, 3, 16'hFFFE, 0, 1'b0); tick();
    set(SEQ, 6'd0, 0, 0, 0, 0, 1'b0); tick();

    // Asynchronous reset while stalled with a redirect outstanding
    set(J, 6'd0, 0, 0, 0, 26'h0000200, 1'b0); tick();
    stall = 1'b1;
    #2 rst = 1'b1;
    #1 check("async_reset_pc", pc, 32'h3000);
    tick(); rst = 1'b0;
    set(SEQ, 6'd0, 0, 0, 0, 0, 1'b0);
    tick(); check("post_reset_pc", pc, 32'h3004);
    tick(); check("post_reset_pc2", pc, 32'h3008);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
